// File: rtl/sample_router_if.sv
// Bundle of fifo-side, mode and per-sink signals of the sample router.
// The router uses the slave view; the fifo/sink environment uses the master view.
interface sample_router_if #(
  parameter int BPS = 24,
  parameter int NCH = 3,
  parameter int MW  = 2
);
  logic [BPS-1:0]     in_sample;
  logic               in_fifo_empty;
  logic [MW-1:0]      in_mode;
  logic [NCH-1:0]     in_sink_ready;
  logic               out_fifo_en;
  logic [NCH*BPS-1:0] out_sample;
  logic [NCH-1:0]     out_sink_en;
  logic               out_busy;
  logic               out_mode_err;
  logic [15:0]        out_underrun_cnt;

  modport slave (
    input  in_sample, in_fifo_empty, in_mode, in_sink_ready,
    output out_fifo_en, out_sample, out_sink_en, out_busy, out_mode_err, out_underrun_cnt
  );

  modport master (
    output in_sample, in_fifo_empty, in_mode, in_sink_ready,
    input  out_fifo_en, out_sample, out_sink_en, out_busy, out_mode_err, out_underrun_cnt
  );
endinterface

// File: rtl/sample_router.sv
// Routes samples from a fixed-latency fifo to one of NCH sinks chosen by in_mode,
// one sample per request, with mode-error flag and saturating underrun counter.
module sample_router #(
  parameter int BPS      = 24,
  parameter int NCH      = 3,
  parameter int FIFO_LAT = 2,
  parameter int MW       = 2
) (
  input logic           in_clk,
  input logic           in_rst_n,
  sample_router_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_READ = 2'd2,
    ST_SEND = 2'd3
  } state_t;

  localparam logic [MW-1:0] NCH_M  = MW'(NCH);
  localparam logic [MW-1:0] ONE_M  = MW'(1'b1);
  localparam logic [2:0]    LAT_M1 = 3'(FIFO_LAT - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [MW-1:0]      r_mode;
  logic [MW-1:0]      w_mode_nxt;
  logic [MW-1:0]      r_sel;
  logic [MW-1:0]      w_sel_nxt;
  logic [2:0]         r_cnt;
  logic [2:0]         w_cnt_nxt;
  logic               r_fifo_en;
  logic               w_fifo_en_nxt;
  logic [NCH-1:0]     r_sink_en;
  logic [NCH-1:0]     w_sink_en_nxt;
  logic               r_busy;
  logic               r_mode_err;
  logic               w_mode_err_nxt;
  logic [15:0]        r_underrun;
  logic               w_underrun_inc;
  logic [NCH*BPS-1:0] r_sample;
  logic [NCH-1:0]     w_sel_oh;
  logic               w_mode_valid;
  logic               w_mode_bad;
  logic               w_ready_sel;

  assign w_sel_oh     = NCH'(1'b1) << r_sel;
  assign w_mode_bad   = (bus.in_mode > NCH_M);
  assign w_mode_valid = (bus.in_mode != '0) && !w_mode_bad;
  assign w_ready_sel  = |(bus.in_sink_ready & w_sel_oh);

  // State register
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output decode; mode is only sampled in IDLE and WAIT
  always_comb begin
    w_state_nxt    = r_state;
    w_mode_nxt     = r_mode;
    w_sel_nxt      = r_sel;
    w_cnt_nxt      = r_cnt;
    w_fifo_en_nxt  = 1'b0;
    w_sink_en_nxt  = '0;
    w_mode_err_nxt = r_mode_err;
    w_underrun_inc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_mode_nxt     = bus.in_mode;
        w_mode_err_nxt = w_mode_bad;
        if (w_mode_valid) begin
          w_state_nxt = ST_WAIT;
          w_sel_nxt   = bus.in_mode - ONE_M;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        w_mode_nxt     = bus.in_mode;
        w_mode_err_nxt = w_mode_bad;
        if (!w_mode_valid) begin
          w_state_nxt = ST_IDLE;
        end else if (bus.in_mode != r_mode) begin
          w_sel_nxt = bus.in_mode - ONE_M;
        end else if (w_ready_sel) begin
          if (!bus.in_fifo_empty) begin
            w_state_nxt   = ST_READ;
            w_cnt_nxt     = 3'd0;
            w_fifo_en_nxt = 1'b1;
          end else begin
            w_underrun_inc = 1'b1;
          end
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_READ: begin
        if (r_cnt == LAT_M1) begin
          w_state_nxt = ST_SEND;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      ST_SEND: begin
        w_sink_en_nxt = w_sel_oh;
        w_state_nxt   = ST_WAIT;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Control and status registers
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_mode     <= '0;
      r_sel      <= '0;
      r_cnt      <= 3'd0;
      r_fifo_en  <= 1'b0;
      r_sink_en  <= '0;
      r_busy     <= 1'b0;
      r_mode_err <= 1'b0;
      r_underrun <= 16'd0;
    end else begin
      r_mode     <= w_mode_nxt;
      r_sel      <= w_sel_nxt;
      r_cnt      <= w_cnt_nxt;
      r_fifo_en  <= w_fifo_en_nxt;
      r_sink_en  <= w_sink_en_nxt;
      r_busy     <= (w_state_nxt == ST_READ) || (w_state_nxt == ST_SEND);
      r_mode_err <= w_mode_err_nxt;
      if (w_underrun_inc && (r_underrun != 16'hFFFF)) begin
        r_underrun <= r_underrun + 16'd1;
      end
    end
  end

  // Sample capture into the selected sink slice, timed with the sink-enable pulse
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_sample <= '0;
    end else if (r_state == ST_SEND) begin
      for (int i = 0; i < NCH; i++) begin
        if (w_sel_oh[i]) begin
          r_sample[i*BPS +: BPS] <= bus.in_sample;
        end
      end
    end
  end

  assign bus.out_fifo_en      = r_fifo_en;
  assign bus.out_sample       = r_sample;
  assign bus.out_sink_en      = r_sink_en;
  assign bus.out_busy         = r_busy;
  assign bus.out_mode_err     = r_mode_err;
  assign bus.out_underrun_cnt = r_underrun;

endmodule

// File: doc/sample_router.md
SAMPLE_ROUTER -- requirements
Module: sample_router

Interface
REQ-001 SHALL have parameter BPS, default 24, bits per sample.
REQ-002 SHALL have parameter NCH, default 3, number of sink channels (1..15).
REQ-003 SHALL have parameter FIFO_LAT, default 2, cycles from fifo read-enable to valid in_sample (1..7).
REQ-004 SHALL have parameter MW, default 2, width of in_mode; MW >= clog2(NCH+1).
REQ-005 in_clk  input  1  sole clock, all state updates on rising edge.
REQ-006 in_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_sample  input  BPS  sample from fifo buffer.
REQ-008 in_fifo_empty  input  1  fifo has no sample.
REQ-009 in_mode  input  MW  0 = idle; k in 1..NCH routes to sink k-1; other values invalid.
REQ-010 in_sink_ready  input  NCH  per-sink request for a new sample.
REQ-011 out_fifo_en  output  1  fifo read-enable pulse.
REQ-012 out_sample  output  NCH*BPS  per-sink registered sample; sink i at bits [i*BPS +: BPS].
REQ-013 out_sink_en  output  NCH  per-sink sample-valid pulse.
REQ-014 out_busy  output  1  high in states READ and SEND.
REQ-015 out_mode_err  output  1  high while latched mode is invalid.
REQ-016 out_underrun_cnt  output  16  saturating count of starved request cycles.

Function
REQ-017 FSM states SHALL be IDLE, WAIT, READ, SEND; all outputs registered.
REQ-018 IDLE: latch in_mode every cycle; valid nonzero -> WAIT with sel = in_mode-1; 0 or invalid -> stay IDLE.
REQ-019 Invalid in_mode (> NCH) SHALL set out_mode_err next cycle, cleared when a valid value is latched; no fifo reads while invalid.
REQ-020 WAIT: in_mode re-latched each cycle; 0/invalid -> IDLE; different valid -> WAIT with new sel, no read that cycle.
REQ-021 WAIT with unchanged mode, in_sink_ready[sel]=1, in_fifo_empty=0 -> READ; out_fifo_en high exactly the following cycle.
REQ-022 READ SHALL count FIFO_LAT cycles from out_fifo_en rising, then enter SEND.
REQ-023 SEND (one cycle): capture in_sample into slice sel of out_sample and pulse out_sink_en[sel] for exactly one cycle, same cycle the new slice appears; then -> WAIT.
REQ-024 Latency: read decision edge to out_sink_en[sel] high SHALL be FIFO_LAT+1 cycles (3 at default).
REQ-025 in_mode changes during READ/SEND SHALL be ignored until SEND completes; transfer always finishes to the original sel.
REQ-026 in_sink_ready and in_fifo_empty SHALL not be re-checked in READ/SEND.
REQ-027 Non-selected out_sample slices SHALL hold their values; at most one out_sink_en bit high at any time.
REQ-028 WAIT with unchanged valid mode, in_sink_ready[sel]=1, in_fifo_empty=1 SHALL increment out_underrun_cnt once per cycle, saturating at 16'hFFFF.
REQ-029 Back-to-back: ready held high with non-empty fifo SHALL yield one sample every FIFO_LAT+2 cycles.

Reset
REQ-030 in_rst_n low SHALL immediately force state IDLE, latched mode 0, out_fifo_en 0, out_sink_en 0, out_sample 0, out_busy 0, out_mode_err 0, out_underrun_cnt 0.
REQ-031 Reset asserted mid-READ/SEND SHALL abort the transfer with no out_sink_en pulse; post-release behaviour as from power-up.
REQ-032 First state change SHALL occur on the first rising edge after in_rst_n deasserts.

Verification (NCH=3, BPS=24, FIFO_LAT=2)
REQ-033 in_mode=2, ready[1]=1, fifo holds 24'hABCDEF -> out_fifo_en one cycle, 3 cycles later out_sink_en=3'b010 one cycle, out_sample[47:24]=24'hABCDEF, other slices 0.
REQ-034 in_mode=1, ready[0] held high, fifo holds 4 samples -> 4 pulses on out_sink_en[0] spaced 4 cycles, samples in fifo order, then out_underrun_cnt increments each cycle.
REQ-035 in_mode switched 1->3 during READ -> current sample delivered to sink 0; next read serves sink 2 only.
REQ-036 in_mode=3'b... value 3 with NCH=2 build -> out_mode_err=1, out_fifo_en never asserts; in_mode=1 -> out_mode_err=0 next cycle.
REQ-037 in_rst_n pulsed low one cycle after out_fifo_en -> no out_sink_en pulse, all outputs 0, out_underrun_cnt=0.
REQ-038 ready[sel]=1, fifo empty for 70000 cycles -> out_underrun_cnt saturates at 16'hFFFF.
